// File: rtl/pulse_xing_pkg.sv
// Shared types and sizing helpers for the pulse crossing scheduler.
package pulse_xing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Counter must hold both TIMEOUT-1 and GAP_CYCLES-1 (GAP_CYCLES fits in 8 bits).
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/pulse_xing_scheduler_if.sv
// Requester/channel-side signal bundle of the pulse crossing scheduler.
interface pulse_xing_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] reqIn;
  logic [NUM_REQ-1:0] pending;
  logic               xferEn;
  logic [IW-1:0]      xferId;
  logic               xferDone;
  logic               busy;
  logic               overflow;
  logic               timeoutErr;

  modport master (
    input  reqIn, xferDone,
    output pending, xferEn, xferId, busy, overflow, timeoutErr
  );

  modport slave (
    output reqIn, xferDone,
    input  pending, xferEn, xferId, busy, overflow, timeoutErr
  );

endinterface

// File: rtl/pulse_xing_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      grant,
  output logic               valid
);

  int idx;

  // Scan from the farthest offset down so the nearest hit is the last write.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (req[idx]) begin
        grant = IW'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_xing_scheduler.sv
// Round-robin scheduler sharing one handshake pulse crossing among NUM_REQ requesters.
module pulse_xing_scheduler
  import pulse_xing_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  pulse_xing_scheduler_if.master xif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(TIMEOUT);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_GAP   = GAP;

  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]         state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      grant;
  logic               gvalid;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] clr;
  logic [IW-1:0]      ptr_nxt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (xif.pending),
    .ptr   (rr_ptr),
    .grant (grant),
    .valid (gvalid)
  );

  always_comb begin
    clr = '0;
    if (state == S_IDLE && gvalid) clr[grant] = 1'b1;
    ptr_nxt = (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      cnt            <= '0;
      xif.pending    <= '0;
      xif.xferEn     <= 1'b0;
      xif.xferId     <= '0;
      xif.busy       <= 1'b0;
      xif.overflow   <= 1'b0;
      xif.timeoutErr <= 1'b0;
    end else begin
      // A re-request on the bit being granted this cycle is a fresh event, not an overflow.
      xif.pending    <= (xif.pending & ~clr) | xif.reqIn;
      xif.overflow   <= |(xif.reqIn & xif.pending & ~clr);
      xif.xferEn     <= 1'b0;
      xif.timeoutErr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gvalid) begin
            xif.xferId <= grant;
            rr_ptr     <= ptr_nxt;
            xif.busy   <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          xif.xferEn <= 1'b1;
          cnt        <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (xif.xferDone || cnt == TO_LAST) begin
            if (!xif.xferDone) xif.timeoutErr <= 1'b1;
            cnt <= '0;
            if (GAP_CYCLES == 0) begin
              xif.busy <= 1'b0;
              state    <= S_IDLE;
            end else begin
              state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            xif.busy <= 1'b0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_xing_scheduler.sv
// Randomized scoreboard bench: a transaction-level model predicts grants, pulses and flags.
module tb_pulse_xing_scheduler;

  localparam int N    = 4;
  localparam int GAPC = 2;
  localparam int TO   = 8;
  localparam int NCYC = 3000;
  localparam int MAXC = NCYC + 4;

  typedef struct {
    int c;
    int id;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pulse_xing_scheduler_if #(.NUM_REQ(N)) xif ();

  pulse_xing_scheduler #(
    .NUM_REQ(N), .GAP_CYCLES(GAPC), .TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .xif   (xif)
  );

  ev_t        xq[$];
  int         toq[$];
  int         ovq[$];
  logic [N-1:0] exp_pend[MAXC];
  logic       exp_busy[MAXC];
  int         exp_id[MAXC];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Model state: arithmetic schedule of the single shared channel.
  int ptr, free_at, busy_from, cur_id, cur_e, cur_wend, done_c, g, e, lat;
  logic [N-1:0] mp, req, clr;
  logic done, rst, in_wait;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, want);
    end
  endtask

  always @(negedge clk) begin : mon
    bit e_en, e_to, e_ov;
    if (chk_en) begin
      chk("pending", xif.pending, exp_pend[cyc]);
      chk("busy", xif.busy, exp_busy[cyc]);
      chk("xferId", xif.xferId, exp_id[cyc]);
      e_en = (xq.size() > 0) && (xq[0].c == cyc);
      chk("xferEn", xif.xferEn, e_en);
      if (e_en) begin
        chk("grant_id", xif.xferId, xq[0].id);
        void'(xq.pop_front());
      end
      e_to = (toq.size() > 0) && (toq[0] == cyc);
      chk("timeoutErr", xif.timeoutErr, e_to);
      if (e_to) void'(toq.pop_front());
      e_ov = (ovq.size() > 0) && (ovq[0] == cyc);
      chk("overflow", xif.overflow, e_ov);
      if (e_ov) void'(ovq.pop_front());
    end
  end

  initial begin
    reset = 1'b1;
    xif.reqIn = '0;
    xif.xferDone = 1'b0;
    ptr = 0; free_at = 4; busy_from = 0; cur_id = 0;
    cur_e = -1; cur_wend = -1; done_c = -1; mp = '0;
    repeat (3) begin
      @(posedge clk);
      cyc++;
    end
    for (int c = 4; c < NCYC; c++) begin
      @(posedge clk);
      cyc = c;
      #1;
      if (c == 4) begin
        exp_pend[4] = '0;
        exp_busy[4] = 1'b0;
        exp_id[4]   = 0;
        chk_en      = 1'b1;
      end
      req     = (c < NCYC - 100) ? N'($urandom & $urandom & $urandom) : '0;
      in_wait = (c >= cur_e) && (c <= cur_wend);
      rst     = in_wait && ($urandom % 60 == 0) && (c < NCYC - 100);
      done    = (c == done_c) || (!in_wait && ($urandom % 8 == 0));
      reset        = rst;
      xif.reqIn    = req;
      xif.xferDone = done;
      if (rst) begin
        // Abort: nothing later than this cycle survives; the pending ack arrives late.
        mp = '0; ptr = 0; cur_id = 0;
        free_at = c + 1; busy_from = c + 1;
        cur_e = -1; cur_wend = -1; done_c = c + 2;
        for (int i = xq.size() - 1; i >= 0; i--) if (xq[i].c > c) xq.delete(i);
        for (int i = toq.size() - 1; i >= 0; i--) if (toq[i] > c) toq.delete(i);
      end else begin
        clr = '0;
        if (c >= free_at && mp != '0) begin
          g = 0;
          for (int k = N - 1; k >= 0; k--) if (mp[(ptr + k) % N]) g = (ptr + k) % N;
          ptr = (g + 1) % N;
          clr[g] = 1'b1;
          cur_id = g;
          e = c + 2;
          lat = int'($urandom % (TO + 3));
          xq.push_back('{e, g});
          if (lat < TO) begin
            done_c   = e + lat;
            cur_wend = e + lat;
          end else begin
            done_c   = -1;
            cur_wend = e + TO - 1;
            toq.push_back(e + TO);
          end
          cur_e     = e;
          busy_from = c + 1;
          free_at   = cur_wend + 1 + GAPC;
        end
        if ((req & mp & ~clr) != '0) ovq.push_back(c + 1);
        mp = (mp & ~clr) | req;
      end
      exp_pend[c+1] = mp;
      exp_id[c+1]   = cur_id;
      exp_busy[c+1] = (c + 1 >= busy_from) && (c + 1 < free_at);
    end
    @(posedge clk);
    cyc = NCYC;
    @(negedge clk);
    #1 chk_en = 1'b0;
    chk("drain_xfer", xq.size(), 0);
    chk("drain_timeout", toq.size(), 0);
    chk("drain_overflow", ovq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
